// File: rtl/median_pkg.sv
// Shared definitions for the median-blur pipeline: pixel width and pixel type.
package median_pkg;

    localparam int PX_W = 8;

    typedef logic [PX_W-1:0] px_t;

endpackage : median_pkg

// File: rtl/median_line_buf.sv
// Single-port line buffer: asynchronous read of the addressed word with a
// synchronous write at the clock edge. A read and a write to the same address
// in one cycle return the old contents (read-before-write).
// Contents are intentionally not reset.
module median_line_buf #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Old contents are visible combinationally until the write edge.
    assign rdata_o = mem_q[addr_i];

    // Store the write word at the addressed location.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule : median_line_buf

// File: rtl/median_window_gen.sv
// 3x3 window generator: buffers two image rows and presents every interior
// 3x3 neighbourhood of a raster-order pixel stream, one cycle after the pixel
// that completes it is accepted.
module median_window_gen #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PX_W  = median_pkg::PX_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [PX_W-1:0] in_px,
    output logic            win_valid,
    output logic [PX_W-1:0] px_1,
    output logic [PX_W-1:0] px_2,
    output logic [PX_W-1:0] px_3,
    output logic [PX_W-1:0] px_4,
    output logic [PX_W-1:0] px_5,
    output logic [PX_W-1:0] px_6,
    output logic [PX_W-1:0] px_7,
    output logic [PX_W-1:0] px_8,
    output logic [PX_W-1:0] px_9,
    output logic            frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             emit_s;
    logic             last_s;
    logic [PX_W-1:0]  lb1_rd_s;
    logic [PX_W-1:0]  lb2_rd_s;
    logic             win_valid_q;
    logic             frame_done_q;

    // Index 0 = top row, 1 = middle row, 2 = bottom row.
    logic [PX_W-1:0]  lcol_q [3];   // column c-2 relative to the next pixel
    logic [PX_W-1:0]  rcol_q [3];   // column c-1 relative to the next pixel
    logic [PX_W-1:0]  px_q   [9];   // emitted window, held between pulses

    // Older row buffer (row r-2): takes the word leaving the newer buffer.
    median_line_buf #(.DEPTH(IMG_W), .WIDTH(PX_W)) u_lb2 (
        .clk     (clk),
        .we_i    (in_valid),
        .addr_i  (col_q),
        .wdata_i (lb1_rd_s),
        .rdata_o (lb2_rd_s)
    );

    // Newer row buffer (row r-1): takes the incoming pixel.
    median_line_buf #(.DEPTH(IMG_W), .WIDTH(PX_W)) u_lb1 (
        .clk     (clk),
        .we_i    (in_valid),
        .addr_i  (col_q),
        .wdata_i (in_px),
        .rdata_o (lb1_rd_s)
    );

    // Raster position advance and emit / frame-end decode for the accepted pixel.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        emit_s = 1'b0;
        last_s = 1'b0;
        if (in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = {COL_W{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
            emit_s = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
            last_s = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end else begin
            emit_s = 1'b0;
            last_s = 1'b0;
        end
    end

    // Counters, column shift registers and registered window outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q        <= {COL_W{1'b0}};
            row_q        <= {ROW_W{1'b0}};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                lcol_q[i] <= {PX_W{1'b0}};
                rcol_q[i] <= {PX_W{1'b0}};
            end
            for (int i = 0; i < 9; i++) begin
                px_q[i] <= {PX_W{1'b0}};
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= emit_s;
            frame_done_q <= last_s;
            if (in_valid) begin
                lcol_q[0] <= rcol_q[0];
                lcol_q[1] <= rcol_q[1];
                lcol_q[2] <= rcol_q[2];
                rcol_q[0] <= lb2_rd_s;
                rcol_q[1] <= lb1_rd_s;
                rcol_q[2] <= in_px;
            end
            if (emit_s) begin
                px_q[0] <= lcol_q[0];
                px_q[1] <= rcol_q[0];
                px_q[2] <= lb2_rd_s;
                px_q[3] <= lcol_q[1];
                px_q[4] <= rcol_q[1];
                px_q[5] <= lb1_rd_s;
                px_q[6] <= lcol_q[2];
                px_q[7] <= rcol_q[2];
                px_q[8] <= in_px;
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign px_1 = px_q[0];
    assign px_2 = px_q[1];
    assign px_3 = px_q[2];
    assign px_4 = px_q[3];
    assign px_5 = px_q[4];
    assign px_6 = px_q[5];
    assign px_7 = px_q[6];
    assign px_8 = px_q[7];
    assign px_9 = px_q[8];

endmodule : median_window_gen

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen on a 4x4 image: expected windows are
// extracted from a bench-side copy of the frame when each pixel is driven.
module tb_median_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        logic [71:0] win;
        logic        fd;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_px;
    logic       win_valid;
    logic [7:0] px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    int win_cnt = 0;
    int r_m = 0;
    int c_m = 0;
    logic [7:0]  img [H][W];
    exp_t        exp_q [$];
    logic [71:0] last_win;
    logic [71:0] cur_win;

    median_window_gen #(.IMG_W(W), .IMG_H(H), .PX_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_px      (in_px),
        .win_valid  (win_valid),
        .px_1       (px_1),
        .px_2       (px_2),
        .px_3       (px_3),
        .px_4       (px_4),
        .px_5       (px_5),
        .px_6       (px_6),
        .px_7       (px_7),
        .px_8       (px_8),
        .px_9       (px_9),
        .frame_done (frame_done)
    );

    assign cur_win = {px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one accepted pixel and record the window it completes, if any.
    task automatic send(input logic [7:0] v);
        exp_t e;
        img[r_m][c_m] = v;
        if (r_m >= 2 && c_m >= 2) begin
            e.win = {img[r_m-2][c_m-2], img[r_m-2][c_m-1], img[r_m-2][c_m],
                     img[r_m-1][c_m-2], img[r_m-1][c_m-1], img[r_m-1][c_m],
                     img[r_m][c_m-2],   img[r_m][c_m-1],   img[r_m][c_m]};
            e.fd  = (r_m == H - 1) && (c_m == W - 1);
            exp_q.push_back(e);
        end
        in_valid = 1'b1;
        in_px    = v;
        @(posedge clk);
        #1;
        if (c_m == W - 1) begin
            c_m = 0;
            r_m = (r_m == H - 1) ? 0 : r_m + 1;
        end else begin
            c_m = c_m + 1;
        end
    endtask

    // Idle cycles with random data on the bus.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_px    = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_count(input string tag, input int exp_cnt);
        total++;
        assert (win_cnt === exp_cnt) else begin
            bad++;
            $error("FAIL %s windows got=%0d exp=%0d", tag, win_cnt, exp_cnt);
        end
        total++;
        assert (exp_q.size() === 0) else begin
            bad++;
            $error("FAIL %s pending got=%0d exp=0", tag, exp_q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        assert ({win_valid, frame_done, cur_win} === 74'd0) else begin
            bad++;
            $error("FAIL %s outputs got=%0h exp=0", tag, {win_valid, frame_done, cur_win});
        end
    endtask

    // Monitor: pop and compare on every window; otherwise outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (reset !== 1'b1) begin
            last_win = 72'd0;
        end else if (win_valid === 1'b1) begin
            win_cnt++;
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_window got=%0h exp=none", cur_win);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                assert (cur_win === e.win) else begin
                    bad++;
                    $error("FAIL window got=%0h exp=%0h", cur_win, e.win);
                end
                total++;
                assert (frame_done === e.fd) else begin
                    bad++;
                    $error("FAIL frame_done got=%0b exp=%0b", frame_done, e.fd);
                end
            end
            last_win = cur_win;
        end else begin
            total++;
            assert (frame_done === 1'b0) else begin
                bad++;
                $error("FAIL stray_frame_done got=%0b exp=0", frame_done);
            end
            total++;
            assert (cur_win === last_win) else begin
                bad++;
                $error("FAIL hold got=%0h exp=%0h", cur_win, last_win);
            end
        end
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_px    = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b1;
        idle(1);

        // Basic contiguous frame 1..16.
        win_cnt = 0;
        for (int v = 1; v <= 16; v++) send(8'(v));
        idle(3);
        check_count("basic", 4);

        // Same frame with random idle gaps.
        win_cnt = 0;
        for (int v = 1; v <= 16; v++) begin
            send(8'(v));
            idle($urandom_range(0, 2));
        end
        idle(3);
        check_count("gaps", 4);

        // Two frames back-to-back.
        win_cnt = 0;
        for (int v = 1; v <= 16; v++) send(8'(v));
        for (int v = 101; v <= 116; v++) send(8'(v));
        idle(3);
        check_count("back_to_back", 8);

        // Partial frame, then asynchronous reset mid-cycle.
        win_cnt = 0;
        for (int v = 1; v <= 6; v++) send(8'(40 + v));
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        exp_q.delete();
        r_m = 0;
        c_m = 0;
        reset = 1'b1;
        idle(1);
        win_cnt = 0;
        for (int v = 1; v <= 16; v++) send(8'(v));
        idle(3);
        check_count("after_reset", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_median_window_gen
